multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Multi-cycle sequencing controller for the single-cycle datapath's instruction set: R-type (opcode 0, func 0–3), load (opcode 1), store (opcode 2), and branch-on-equal (opcode 3). It replaces one-shot combinational decode with a registered state machine. The FSM steps the shared datapath through fetch, decode, execute, memory and writeback. It waits on a memory ready handshake and counts retired instructions. It sits between the instruction register/memory interface and the register file, ALU, PC and memory-control muxes.

## Interface
- COUNT_W, 16, width of retired-instruction counter
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  6  instruction register opcode field, stable from DECODE onward
- func  in  6  instruction register func field
- zero  in  1  ALU zero flag, sampled in BRANCH
- mem_ready  in  1  memory has completed current read/write this cycle
- RegDst  out  1  1 = rd destination, 0 = rt
- ALU_Src  out  1  1 = immediate, 0 = register B
- MemToReg  out  1  1 = writeback from memory data
- RegWrite  out  1  register file write strobe
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- ALU_op  out  2  0 add, 1 sub, 2 and, 3 or (equals func[1:0] for R-type)
- IorD  out  1  memory address select: 0 = PC, 1 = ALU result
- IRWrite  out  1  instruction register load strobe
- PCWrite  out  1  PC load strobe
- PCSrc  out  1  0 = PC+4, 1 = branch target
- illegal  out  1  one-cycle pulse on undecodable instruction
- state  out  4  current state encoding
- instr_count  out  COUNT_W  retired instructions, wraps modulo 2^COUNT_W

## Operation
- State encoding: FETCH=0, DECODE=1, EXEC_R=2, WB_R=3, ADDR=4, MEM_RD=5, WB_LD=6, MEM_WR=7, BRANCH=8. Codes 9–15 are unused and go to FETCH on the next edge.
- Control outputs are combinational from state, plus opcode/func/zero/mem_ready where noted. Unlisted outputs are 0 in each state.
- FETCH: IorD=0, MemRead=1. If mem_ready=1: IRWrite=1, PCWrite=1, PCSrc=0, go to DECODE. Otherwise hold.
- DECODE:
  - opcode 0 with func 0–3 → EXEC_R.
  - opcode 1 or 2 → ADDR.
  - opcode 3 → BRANCH.
  - Anything else: illegal=1, go to FETCH; not counted as retired.
- EXEC_R: ALU_Src=0, ALU_op=func[1:0], go to WB_R.
- WB_R: RegDst=1, MemToReg=0, RegWrite=1, ALU_op=func[1:0], go to FETCH, retire.
- ADDR: ALU_Src=1, ALU_op=0. Go to MEM_RD if opcode=1, MEM_WR if opcode=2.
- MEM_RD: IorD=1, MemRead=1, ALU_Src=1. Go to WB_LD on mem_ready, else hold.
- WB_LD: RegDst=0, MemToReg=1, RegWrite=1, go to FETCH, retire.
- MEM_WR: IorD=1, MemWrite=1, ALU_Src=1. On mem_ready go to FETCH and retire, else hold. MemWrite stays high for every wait cycle.
- BRANCH: ALU_Src=0, ALU_op=1, PCSrc=1, PCWrite=zero. Go to FETCH, retire whether taken or not.
- MemRead and MemWrite are never both 1. RegWrite is never 1 outside WB_R and WB_LD.
- instr_count increments by 1 on the edge that leaves a retiring state and wraps to 0 past all-ones.

## Timing
- Reset (asynchronous, any cycle, including mid-memory-wait):
  - state=FETCH, instr_count=0.
  - While rst=1, all control outputs and illegal are forced 0; state reads 0.
- First FETCH request is asserted in the first cycle after rst deasserts.
- Minimum cycles per instruction with mem_ready=1 in every memory cycle: R-type 4, load 5, store 4, branch 3, illegal 2.
- Each cycle with mem_ready=0 in FETCH, MEM_RD or MEM_WR adds one cycle. The request stays asserted and addresses stay stable.
- mem_ready is ignored in all other states.
- opcode/func changes after DECODE have no effect on the path already chosen. Exception: ALU_op in EXEC_R/WB_R follows func, which the datapath holds stable via the IR.

## Test plan
- Reset and fetch: rst=1 mid-run → state=0, instr_count=0, all strobes 0. Release with mem_ready=1 → FETCH shows MemRead=1, IRWrite=1, PCWrite=1.
- R-type sweep: opcode 0, func 0/1/2/3, mem_ready=1.
  - Each instruction runs 4 cycles.
  - WB_R shows RegDst=1, RegWrite=1, ALU_op=0/1/2/3.
  - instr_count reaches 4.
- Load with 3 wait cycles: opcode 1, mem_ready low 3 cycles in MEM_RD.
  - MEM_RD holds 4 cycles with IorD=1, MemRead=1, MemWrite=0.
  - WB_LD shows MemToReg=1, RegWrite=1, RegDst=0.
- Store then branch:
  - Store: opcode 2 → MemWrite=1 only in MEM_WR; RegWrite never 1.
  - Branch: opcode 3, zero=1 → PCWrite=1, PCSrc=1 in BRANCH.
  - Branch: opcode 3, zero=0 → PCWrite=0.
  - Both branches retire.
- Illegal instructions: opcode 0/func 5, and opcode 7.
  - illegal pulses 1 cycle in DECODE, next state FETCH.
  - instr_count unchanged.
- Counter wrap and async reset mid-wait:
  - COUNT_W=4: 16 branches → instr_count wraps to 0.
  - rst asserted during MEM_WR with mem_ready=0 → MemWrite drops immediately, state=0.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multi-cycle sequencing FSM: walks the shared datapath through fetch, decode,
// execute, memory and writeback, waits on mem_ready and counts retirements.
module multicycle_controller #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic [5:0]         func,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               RegDst,
  output logic               ALU_Src,
  output logic               MemToReg,
  output logic               RegWrite,
  output logic               MemRead,
  output logic               MemWrite,
  output logic [1:0]         ALU_op,
  output logic               IorD,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic               PCSrc,
  output logic               illegal,
  output logic [3:0]         state,
  output logic [COUNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    EXEC_R = 4'd2,
    WB_R   = 4'd3,
    ADDR   = 4'd4,
    MEM_RD = 4'd5,
    WB_LD  = 4'd6,
    MEM_WR = 4'd7,
    BRANCH = 4'd8
  } state_t;

  state_t             state_q, state_d;
  logic               is_load_q, is_load_d;
  logic               retire;
  logic [COUNT_W-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FETCH;
      is_load_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      is_load_q <= is_load_d;
      if (retire) count_q <= count_q + COUNT_W'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    is_load_d = is_load_q;
    retire    = 1'b0;
    RegDst    = 1'b0;
    ALU_Src   = 1'b0;
    MemToReg  = 1'b0;
    RegWrite  = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    ALU_op    = 2'd0;
    IorD      = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    PCSrc     = 1'b0;
    illegal   = 1'b0;
    case (state_q)
      FETCH: begin
        MemRead = 1'b1;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        // Load/store direction is latched here so later opcode changes cannot redirect ADDR.
        is_load_d = (opcode == 6'd1);
        if (opcode == 6'd0 && func[5:2] == 4'd0)  state_d = EXEC_R;
        else if (opcode == 6'd1 || opcode == 6'd2) state_d = ADDR;
        else if (opcode == 6'd3)                   state_d = BRANCH;
        else begin
          illegal = 1'b1;
          state_d = FETCH;
        end
      end
      EXEC_R: begin
        ALU_op  = func[1:0];
        state_d = WB_R;
      end
      WB_R: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        ALU_op   = func[1:0];
        retire   = 1'b1;
        state_d  = FETCH;
      end
      ADDR: begin
        ALU_Src = 1'b1;
        state_d = is_load_q ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
        ALU_Src = 1'b1;
        if (mem_ready) state_d = WB_LD;
      end
      WB_LD: begin
        MemToReg = 1'b1;
        RegWrite = 1'b1;
        retire   = 1'b1;
        state_d  = FETCH;
      end
      MEM_WR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        ALU_Src  = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = FETCH;
        end
      end
      BRANCH: begin
        ALU_op  = 2'd1;
        PCSrc   = 1'b1;
        PCWrite = zero;
        retire  = 1'b1;
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
    // Reset overrides every strobe immediately, even mid-cycle.
    if (rst) begin
      RegDst   = 1'b0;
      ALU_Src  = 1'b0;
      MemToReg = 1'b0;
      RegWrite = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      ALU_op   = 2'd0;
      IorD     = 1'b0;
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      PCSrc    = 1'b0;
      illegal  = 1'b0;
    end
  end

  assign state       = rst ? 4'd0 : state_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-instruction cycle traces are
// built from the instruction rules, queued, driven, and checked by a monitor.
module tb_multicycle_controller;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [5:0]    opcode = '0, func = '0;
  logic          zero = 1'b0, mem_ready = 1'b0;
  logic          RegDst, ALU_Src, MemToReg, RegWrite, MemRead, MemWrite;
  logic [1:0]    ALU_op;
  logic          IorD, IRWrite, PCWrite, PCSrc, illegal;
  logic [3:0]    state;
  logic [CW-1:0] instr_count;

  multicycle_controller #(.COUNT_W(CW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func(func), .zero(zero),
    .mem_ready(mem_ready), .RegDst(RegDst), .ALU_Src(ALU_Src),
    .MemToReg(MemToReg), .RegWrite(RegWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .ALU_op(ALU_op), .IorD(IorD), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .PCSrc(PCSrc), .illegal(illegal), .state(state),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]    op;
    logic [5:0]    fn;
    logic          z;
    logic          mr;
    logic [3:0]    st;
    logic [12:0]   ct;
    logic [CW-1:0] cnt;
  } cyc_t;

  cyc_t stim_q[$];
  cyc_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   mcnt   = 0;

  logic [12:0] act_ct;
  assign act_ct = {RegDst, ALU_Src, MemToReg, RegWrite, MemRead, MemWrite,
                   ALU_op, IorD, IRWrite, PCWrite, PCSrc, illegal};

  // Control word: {RegDst,ALU_Src,MemToReg,RegWrite,MemRead,MemWrite,ALU_op,IorD,IRWrite,PCWrite,PCSrc,illegal}
  function automatic logic [12:0] cw(input logic rd, as, m2r, rw, mrd, mwr,
                                     input logic [1:0] aop,
                                     input logic iord, irw, pcw, pcs, ill);
    return {rd, as, m2r, rw, mrd, mwr, aop, iord, irw, pcw, pcs, ill};
  endfunction

  task automatic cyc(input logic [5:0] op, fn, input logic z, mr,
                     input logic [3:0] st, input logic [12:0] ct);
    cyc_t c;
    c.op = op; c.fn = fn; c.z = z; c.mr = mr; c.st = st; c.ct = ct;
    c.cnt = CW'(mcnt);
    stim_q.push_back(c);
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected trace of one instruction, written from the instruction-class rules.
  task automatic gen_instr(input logic [5:0] op, fn, input logic z,
                           input int fwait, mwait);
    bit is_r, is_ld, is_st, is_br;
    for (int i = 0; i < fwait; i++) cyc(op, fn, rb(), 1'b0, 4'd0, cw(0,0,0,0,1,0,2'd0,0,0,0,0,0));
    cyc(op, fn, rb(), 1'b1, 4'd0, cw(0,0,0,0,1,0,2'd0,0,1,1,0,0));
    is_r  = (op == 0) && (fn < 4);
    is_ld = (op == 1);
    is_st = (op == 2);
    is_br = (op == 3);
    if (!(is_r || is_ld || is_st || is_br)) begin
      cyc(op, fn, rb(), rb(), 4'd1, cw(0,0,0,0,0,0,2'd0,0,0,0,0,1));
      return;
    end
    cyc(op, fn, rb(), rb(), 4'd1, 13'd0);
    if (is_r) begin
      cyc(op, fn, rb(), rb(), 4'd2, cw(0,0,0,0,0,0,fn[1:0],0,0,0,0,0));
      cyc(op, fn, rb(), rb(), 4'd3, cw(1,0,0,1,0,0,fn[1:0],0,0,0,0,0));
      mcnt = (mcnt + 1) % (1 << CW);
    end else if (is_br) begin
      cyc(op, fn, z, rb(), 4'd8, cw(0,0,0,0,0,0,2'd1,0,0,z,1,0));
      mcnt = (mcnt + 1) % (1 << CW);
    end else begin
      cyc(op, fn, rb(), rb(), 4'd4, cw(0,1,0,0,0,0,2'd0,0,0,0,0,0));
      for (int i = 0; i <= mwait; i++) begin
        if (is_ld) cyc(op, fn, rb(), i == mwait, 4'd5, cw(0,1,0,0,1,0,2'd0,1,0,0,0,0));
        else       cyc(op, fn, rb(), i == mwait, 4'd7, cw(0,1,0,0,0,1,2'd0,1,0,0,0,0));
      end
      if (is_ld) cyc(op, fn, rb(), rb(), 4'd6, cw(0,0,1,1,0,0,2'd0,0,0,0,0,0));
      mcnt = (mcnt + 1) % (1 << CW);
    end
  endtask

  task automatic drive_n(input int n);
    cyc_t s;
    for (int i = 0; (n < 0 || i < n) && stim_q.size() > 0; i++) begin
      s = stim_q.pop_front();
      opcode = s.op; func = s.fn; zero = s.z; mem_ready = s.mr;
      exp_q.push_back(s);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every driven cycle presents an output word to be scored.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cyc_t e;
      e = exp_q.pop_front();
      checks++;
      if (state !== e.st || act_ct !== e.ct || instr_count !== e.cnt) begin
        errors++;
        $display("FAIL cycle op=%0d fn=%0d: got st=%0d ctl=%h cnt=%0d expected st=%0d ctl=%h cnt=%0d",
                 e.op, e.fn, state, act_ct, instr_count, e.st, e.ct, e.cnt);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    logic [5:0] op, fn;
    mem_ready = 1'b1;
    opcode    = 6'd2;
    #3;
    check("reset_ctl",   32'(act_ct), 32'd0);
    check("reset_state", 32'(state), 32'd0);
    check("reset_count", 32'(instr_count), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int f = 0; f < 4; f++) gen_instr(6'd0, 6'(f), 1'b0, 0, 0);
    gen_instr(6'd1, 6'd9, 1'b0, 1, 3);
    gen_instr(6'd2, 6'd0, 1'b0, 0, 0);
    gen_instr(6'd3, 6'd0, 1'b1, 0, 0);
    gen_instr(6'd3, 6'd0, 1'b0, 0, 0);
    gen_instr(6'd0, 6'd5, 1'b0, 0, 0);
    gen_instr(6'd7, 6'd0, 1'b0, 0, 0);
    drive_n(-1);
    check("count_directed", 32'(instr_count), 32'd8);

    // Asynchronous reset during a stalled store.
    gen_instr(6'd2, 6'd0, 1'b0, 0, 5);
    drive_n(4);
    opcode = 6'd2; mem_ready = 1'b0;
    #1;
    check("memwr_wait_write", 32'(MemWrite), 32'd1);
    check("memwr_wait_state", 32'(state), 32'd7);
    rst = 1'b1;
    #1;
    check("async_rst_ctl",   32'(act_ct), 32'd0);
    check("async_rst_state", 32'(state), 32'd0);
    check("async_rst_count", 32'(instr_count), 32'd0);
    stim_q.delete();
    mcnt = 0;
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 16; i++) gen_instr(6'd3, 6'(i), rb(), 0, 0);
    drive_n(-1);
    check("count_wrap", 32'(instr_count), 32'd0);

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 5))
        0, 5: begin op = 6'd0; fn = 6'($urandom_range(0, 3)); end
        1:    begin op = 6'd1; fn = 6'($urandom); end
        2:    begin op = 6'd2; fn = 6'($urandom); end
        3:    begin op = 6'd3; fn = 6'($urandom); end
        default: begin
          if (rb()) begin op = 6'd0; fn = 6'($urandom_range(4, 63)); end
          else      begin op = 6'($urandom_range(4, 63)); fn = 6'($urandom); end
        end
      endcase
      gen_instr(op, fn, rb(), $urandom_range(0, 3), $urandom_range(0, 3));
    end
    drive_n(-1);
    check("count_random", 32'(instr_count), 32'(mcnt));

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
